// File: rtl/vga_timing.sv
// Raster timing generator: free-running x/y counters, sync/blank decode and a
// programmable-depth delay line that keeps sync/blank aligned with downstream pixel data.
module vga_timing #(
    parameter int unsigned H_VIS  = 800,
    parameter int unsigned H_FP   = 56,
    parameter int unsigned H_SYNC = 120,
    parameter int unsigned H_BP   = 64,
    parameter int unsigned V_VIS  = 600,
    parameter int unsigned V_FP   = 37,
    parameter int unsigned V_SYNC = 6,
    parameter int unsigned V_BP   = 23,
    parameter bit          HS_POL = 1'b1,
    parameter bit          VS_POL = 1'b1,
    parameter int unsigned DLY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        line_start,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_MAX = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VEND = 11'(H_VIS);
    localparam logic [10:0] H_SS  = 11'(H_VIS + H_FP);
    localparam logic [10:0] H_SE  = 11'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_MAX = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VEND = 10'(V_VIS);
    localparam logic [9:0]  V_SS  = 10'(V_VIS + V_FP);
    localparam logic [9:0]  V_SE  = 10'(V_VIS + V_FP + V_SYNC - 1);

    // Pipe stage layout: {hsync, vsync, blank}, already at output polarity.
    localparam logic [2:0] PIPE_IDLE = {~HS_POL, ~VS_POL, 1'b1};

    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        hs_raw, vs_raw, bl_raw;
    logic [2:0]  pipe_in;
    logic [2:0]  pipe_q [DLY];

    always_comb begin
        x_d = x_q + 11'd1;
        y_d = y_q;
        if (x_q == H_MAX) begin
            x_d = '0;
            y_d = (y_q == V_MAX) ? '0 : y_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (en) begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    always_comb begin
        hs_raw  = (x_q >= H_SS) && (x_q <= H_SE);
        vs_raw  = (y_q >= V_SS) && (y_q <= V_SE);
        bl_raw  = (x_q >= H_VEND) || (y_q >= V_VEND);
        pipe_in = {hs_raw ? HS_POL : ~HS_POL, vs_raw ? VS_POL : ~VS_POL, bl_raw};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DLY; i++) begin
                pipe_q[i] <= PIPE_IDLE;
            end
        end else if (en) begin
            pipe_q[0] <= pipe_in;
            for (int i = 1; i < DLY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Strobes also gated by rst so they stay low while x/y are held at zero in reset.
    always_comb begin
        x           = x_q;
        y           = y_q;
        {hsync, vsync, blank} = pipe_q[DLY-1];
        line_start  = en && rst && (x_q == '0);
        frame_start = en && rst && (x_q == '0) && (y_q == '0);
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default-size instance plus a tiny-frame instance (DLY=3,
// active-low syncs) so frame wraps and vsync are reachable in a short run.
module tb_vga_timing;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;

    logic [10:0] dx, sx;
    logic [9:0]  dy, sy;
    logic        dhs, dvs, dbl, dls, dfs;
    logic        shs, svs, sbl, sls, sfs;

    always #5 clk = ~clk;

    vga_timing dut (
        .clk(clk), .rst(rst), .en(en), .x(dx), .y(dy), .hsync(dhs), .vsync(dvs),
        .blank(dbl), .line_start(dls), .frame_start(dfs)
    );

    vga_timing #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .DLY(3)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en), .x(sx), .y(sy), .hsync(shs), .vsync(svs),
        .blank(sbl), .line_start(sls), .frame_start(sfs)
    );

    typedef struct {
        int hv, hfp, hs, hbp, vv, vfp, vs, vbp;
        bit hpol, vpol;
        int dly;
    } prm_t;

    typedef struct {
        int x, y;
        logic [3:0] hs_c, vs_c, bl_c;   // raw active bits, bit 0 = newest
    } mdl_t;

    typedef struct {
        int n;
        logic en;
        logic [10:0] x;
        logic [9:0] y;
        logic hs, bl, ls;
    } vec_t;

    int checks = 0;
    int errors = 0;
    prm_t pd, ps;
    mdl_t md, ms;
    logic [25:0] q_d[$], q_s[$];
    int n_en = 0;
    int hs_cnt = 0, bl_lo_cnt = 0, ls_cnt = 0, fs_s_cnt = 0, wrap_s_cnt = 0, ymax_s = 0;
    logic [10:0] px_s;
    logic [9:0] py_s;

    function automatic logic [25:0] pk(int xv, int yv, logic h, logic v, logic b, logic l, logic f);
        return {11'(xv), 10'(yv), h, v, b, l, f};
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.x = 0; m.y = 0; m.hs_c = '0; m.vs_c = '0; m.bl_c = '1;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, prm_t p);
        logic hr, vr, br;
        hr = (m.x >= p.hv + p.hfp) && (m.x <= p.hv + p.hfp + p.hs - 1);
        vr = (m.y >= p.vv + p.vfp) && (m.y <= p.vv + p.vfp + p.vs - 1);
        br = (m.x >= p.hv) || (m.y >= p.vv);
        m.hs_c = {m.hs_c[2:0], hr};
        m.vs_c = {m.vs_c[2:0], vr};
        m.bl_c = {m.bl_c[2:0], br};
        if (m.x == p.hv + p.hfp + p.hs + p.hbp - 1) begin
            m.x = 0;
            m.y = (m.y == p.vv + p.vfp + p.vs + p.vbp - 1) ? 0 : m.y + 1;
        end else begin
            m.x = m.x + 1;
        end
        return m;
    endfunction

    function automatic logic [25:0] mdl_out(mdl_t m, prm_t p, logic en_v, logic rst_v);
        logic h, v, l;
        h = m.hs_c[p.dly-1] ? p.hpol : !p.hpol;
        v = m.vs_c[p.dly-1] ? p.vpol : !p.vpol;
        l = en_v && rst_v && (m.x == 0);
        return pk(m.x, m.y, h, v, m.bl_c[p.dly-1], l, l && (m.y == 0));
    endfunction

    task automatic chk(input string nm, input logic [25:0] act, input logic [25:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // One clock: drive en, predict, let the edge happen, then score both instances.
    task automatic step(input logic en_v);
        en = en_v;
        if (en_v) begin
            md = mdl_step(md, pd);
            ms = mdl_step(ms, ps);
        end
        q_d.push_back(mdl_out(md, pd, en_v, 1'b1));
        q_s.push_back(mdl_out(ms, ps, en_v, 1'b1));
        px_s = sx;
        py_s = sy;
        @(posedge clk);
        #1;
        chk("sb_default", {dx, dy, dhs, dvs, dbl, dls, dfs}, q_d.pop_front());
        chk("sb_small", {sx, sy, shs, svs, sbl, sls, sfs}, q_s.pop_front());
        if (en_v) begin
            n_en++;
            if (n_en <= 1040) begin
                if (dhs) hs_cnt++;
                if (!dbl) bl_lo_cnt++;
                if (dls) ls_cnt++;
            end
            if (n_en <= 1536) begin
                if (sfs) fs_s_cnt++;
                if (int'(sy) > ymax_s) ymax_s = int'(sy);
                if (px_s == 11'd15 && py_s == 10'd11 && sx == 11'd0 && sy == 10'd0)
                    wrap_s_cnt++;
            end
        end
    endtask

    vec_t vecs[13];
    int guard;

    initial begin
        pd = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1, 1};
        ps = '{8, 2, 3, 3, 6, 2, 2, 2, 1'b0, 1'b0, 3};
        vecs[0]  = '{1,   1'b1, 11'd1,    10'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{799, 1'b1, 11'd800,  10'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1,   1'b1, 11'd801,  10'd0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{55,  1'b1, 11'd856,  10'd0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1,   1'b1, 11'd857,  10'd0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{119, 1'b1, 11'd976,  10'd0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1,   1'b1, 11'd977,  10'd0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{62,  1'b1, 11'd1039, 10'd0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1,   1'b1, 11'd0,    10'd1, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1,   1'b1, 11'd1,    10'd1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{499, 1'b1, 11'd500,  10'd1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{10,  1'b0, 11'd500,  10'd1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1,   1'b1, 11'd501,  10'd1, 1'b0, 1'b0, 1'b0};

        // Reset with en high: strobes must still stay low.
        rst = 1'b0;
        en  = 1'b1;
        md  = mdl_reset();
        ms  = mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_default", {dx, dy, dhs, dvs, dbl, dls, dfs}, pk(0, 0, 0, 0, 1, 0, 0));
        chk("reset_small", {sx, sy, shs, svs, sbl, sls, sfs}, pk(0, 0, 1, 1, 1, 0, 0));

        rst = 1'b1;
        #1;
        chk("release_strobes", {dx, dy, dhs, dvs, dbl, dls, dfs}, pk(0, 0, 0, 0, 1, 1, 1));
        chk("release_small", {sx, sy, shs, svs, sbl, sls, sfs}, pk(0, 0, 1, 1, 1, 1, 1));

        for (int i = 0; i < 13; i++) begin
            for (int k = 0; k < vecs[i].n; k++) step(vecs[i].en);
            chk($sformatf("vec%0d", i), {15'd0, dx, dy, dhs, dbl, dls},
                {15'd0, vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].bl, vecs[i].ls});
        end

        chk_int("hsync_width_line0", hs_cnt, 120);
        chk_int("visible_pixels_line0", bl_lo_cnt, 800);
        chk_int("line_start_count_line0", ls_cnt, 1);

        // Run on until the small frame is in vsync while the default line is at x=900.
        guard = 0;
        while (!(md.x == 900 && ms.y == 9 && ms.x >= 3) && guard < 20000) begin
            step(1'b1);
            guard++;
        end
        chk_int("reach_x900_timeout", int'(guard >= 20000), 0);
        chk_int("small_frame_starts", fs_s_cnt, 8);
        chk_int("small_frame_wraps", wrap_s_cnt, 8);
        chk_int("small_ymax", ymax_s, 11);
        chk("pre_reset_sync", {24'd0, dhs, svs}, {24'd0, 1'b1, 1'b0});

        // Asynchronous reset mid-cycle, no clock edge in between.
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_default", {dx, dy, dhs, dvs, dbl, dls, dfs}, pk(0, 0, 0, 0, 1, 0, 0));
        chk("async_reset_small", {sx, sy, shs, svs, sbl, sls, sfs}, pk(0, 0, 1, 1, 1, 0, 0));
        md = mdl_reset();
        ms = mdl_reset();
        @(posedge clk);
        #1;
        chk("reset_held_default", {dx, dy, dhs, dvs, dbl, dls, dfs}, pk(0, 0, 0, 0, 1, 0, 0));
        rst = 1'b1;
        #1;
        chk("rerelease_default", {dx, dy, dhs, dvs, dbl, dls, dfs}, pk(0, 0, 0, 0, 1, 1, 1));
        step(1'b1);
        chk("restart_first_pixel", {dx, dy, dhs, dvs, dbl, dls, dfs}, pk(1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 40; k++) step(1'b1);
        chk("restart_after_41", {15'd0, dx, dy, 1'b0}, {15'd0, 11'd41, 10'd0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates raster timing for the 800x600@72 Hz display path at a 50 MHz pixel clock.
- Produces the free-running pixel coordinates x/y that feed the colour-bar/pattern generator directly downstream.
- Also produces hsync, vsync and blank, each delayed by a programmable number of cycles so they stay aligned with the registered colour output of the downstream stage.
- Provides frame and line strobes for other consumers.

Parameters:
H_VIS, 800, visible pixels per line
H_FP, 56, horizontal front porch (pixels)
H_SYNC, 120, horizontal sync width (pixels)
H_BP, 64, horizontal back porch (pixels); H_TOTAL = sum of the four = 1040
V_VIS, 600, visible lines per frame
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 23, vertical back porch (lines); V_TOTAL = sum of the four = 666
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level
DLY, 1, pipeline delay (1..4) applied to hsync/vsync/blank outputs

Ports:
clk  input  1  pixel clock, 50 MHz
rst  input  1  asynchronous reset, active-low
en  input  1  count enable; when 0 all state holds
x  output  11  horizontal pixel counter, 0..H_TOTAL-1
y  output  10  vertical line counter, 0..V_TOTAL-1
hsync  output  1  horizontal sync, delayed DLY cycles relative to x/y
vsync  output  1  vertical sync, delayed DLY cycles relative to x/y
blank  output  1  1 outside the visible area, delayed DLY cycles relative to x/y
line_start  output  1  one-cycle pulse coincident with x==0 (undelayed)
frame_start  output  1  one-cycle pulse coincident with x==0 and y==0 (undelayed)

Behaviour:
- Reset (rst=0, asynchronous):
  - x=0, y=0.
  - hsync=!HS_POL, vsync=!VS_POL, blank=1.
  - line_start=0, frame_start=0.
  - All delay-line stages load these inactive values.
- Counting, on each clk rising edge with rst=1 and en=1:
  - x increments; at x==H_TOTAL-1, x wraps to 0.
  - y increments only on the cycle x wraps; at y==V_TOTAL-1 with x wrapping, y wraps to 0.
  - x and y are registers, never combinational.
- Undelayed sync/blank terms are decoded from the current x/y:
  - hs_raw: active when H_VIS+H_FP <= x <= H_VIS+H_FP+H_SYNC-1 (856..975 at defaults).
  - vs_raw: active when V_VIS+V_FP <= y <= V_VIS+V_FP+V_SYNC-1 (637..642 at defaults).
  - bl_raw: 1 when x >= H_VIS or y >= V_VIS.
- Output delay:
  - hs_raw, vs_raw and bl_raw each pass through a DLY-stage register chain.
  - hsync, vsync and blank are taken from the last stage.
  - Net effect: hsync(t) = decode(x(t-DLY)), and likewise for vsync and blank.
- Strobes:
  - line_start and frame_start are combinational decodes of the registered x/y, gated by en.
  - frame_start implies line_start.
- en=0:
  - Counters and the delay chains freeze.
  - Strobes are forced to 0.
  - Outputs hold their last values.
  - On en=1, counting resumes from the held x/y with no skipped or repeated pixel.
- Reset released mid-frame: counting restarts at x=0, y=0 on the first enabled edge after release. The first frame_start is asserted immediately while x=y=0.
- Boundary values at defaults:
  - Last pixel of a line is x=1039; the next cycle is x=0 with y+1.
  - Last pixel of a frame is (1039, 665); the next cycle is (0, 0).
  - Frame length is 1040*666 = 692640 clocks.
- Widths: counter compares are unsigned, at 11 bits for x and 10 bits for y. Parameter sums must fit these widths; this is not checked in RTL.

Test Plan:
- Reset then en=1 for 1040 cycles -> x runs 0..1039 then reads 0; y goes 0->1 exactly on the wrap cycle; line_start high at cycles 0 and 1040 only.
- Full frame (692640 cycles) -> frame_start pulses exactly once per frame; y max observed 665; pixel (1039, 665) is followed by (0, 0).
- DLY=1, defaults -> hsync high for exactly 120 clocks, rising 1 cycle after x==856 and falling 1 cycle after x==975; vsync high for 6 lines, starting on the cycle after (x=0, y=637).
- Blank check -> blank=0 for exactly 800 cycles per visible line (one cycle after x=0..799); blank=1 for the entire line while y in 600..665.
- en toggled low for 10 cycles at x=500, y=300 -> x/y/hsync/vsync/blank held constant; after en=1, x=501 on the next edge; line count is unaffected.
- rst pulsed low asynchronously mid-cycle at x=900, y=640 -> x=0, y=0, hsync=0, vsync=0, blank=1 immediately without waiting for a clock edge; after release, counting restarts from (0, 0).
